// File: rtl/adr_deserializer.sv
// Address capture from two 74HC165-style PISO chains into a 2*BITS word with a valid strobe.
// Optional build macro ADR_SYNC_EN: 2-flop pin synchronizers and a LOW phase stretched by two cycles.
//
// state  | meaning
// IDLE   | chains in shift mode, SRCLK low, waiting for i_start
// LOAD   | SHLD low for LOAD_CYCLES cycles, parallel load into the chains
// LOW    | SRCLK low half-period; last cycle samples QH of both chains
// HIGH   | SRCLK high half-period; the rising edge advances the chains
// DONE   | publish captured word, one-cycle o_valid
module adr_deserializer #(
  parameter int BITS        = 8,
  parameter int DIV         = 2,
  parameter int LOAD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              adrin1,
  input  logic              adrin2,
  output logic              o_shld,
  output logic              o_serclk,
  output logic [2*BITS-1:0] o_address,
  output logic              o_valid,
  output logic              o_busy
);

`ifdef ADR_SYNC_EN
  localparam int LOW_LEN = DIV + 2;
`else
  localparam int LOW_LEN = DIV;
`endif
  localparam int HPW = $clog2(DIV + 2);
  localparam int LDW = $clog2(LOAD_CYCLES + 1);
  localparam int NW  = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LDW-1:0]      ld_cnt_q, ld_cnt_d;
  logic [HPW-1:0]      hp_cnt_q, hp_cnt_d;
  logic [NW-1:0]       n_q, n_d;
  logic [BITS-1:0]     sr1_q, sr1_d;
  logic [BITS-1:0]     sr2_q, sr2_d;
  logic [2*BITS-1:0]   addr_q, addr_d;
  logic                shld_q, serclk_q, valid_q, busy_q;
  logic                smp1, smp2;
  logic [BITS-1:0]     sr1_sh, sr2_sh;

`ifdef ADR_SYNC_EN
  logic [1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sync1_q[0], adrin1};
      sync2_q <= {sync2_q[0], adrin2};
    end
  end

  assign smp1 = sync1_q[1];
  assign smp2 = sync2_q[1];
`else
  assign smp1 = adrin1;
  assign smp2 = adrin2;
`endif

  // QH arrives MSB first, so a plain left shift lands bit 0 last.
  assign sr1_sh = {sr1_q[BITS-2:0], smp1};
  assign sr2_sh = {sr2_q[BITS-2:0], smp2};

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    hp_cnt_d = hp_cnt_q;
    n_d      = n_q;
    sr1_d    = sr1_q;
    sr2_d    = sr2_q;
    addr_d   = addr_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_LOAD;
          ld_cnt_d = LDW'(LOAD_CYCLES - 1);
        end
      end
      S_LOAD: begin
        if (ld_cnt_q == '0) begin
          state_d  = S_LOW;
          hp_cnt_d = HPW'(LOW_LEN - 1);
          n_d      = '0;
        end else begin
          ld_cnt_d = ld_cnt_q - 1'b1;
        end
      end
      S_LOW: begin
        if (hp_cnt_q == '0) begin
          sr1_d = sr1_sh;
          sr2_d = sr2_sh;
          if (n_q == NW'(BITS - 1)) begin
            state_d = S_DONE;
            addr_d  = {sr1_sh, sr2_sh};
          end else begin
            state_d  = S_HIGH;
            hp_cnt_d = HPW'(DIV - 1);
          end
        end else begin
          hp_cnt_d = hp_cnt_q - 1'b1;
        end
      end
      S_HIGH: begin
        if (hp_cnt_q == '0) begin
          state_d  = S_LOW;
          hp_cnt_d = HPW'(LOW_LEN - 1);
          n_d      = n_q + 1'b1;
        end else begin
          hp_cnt_d = hp_cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin-facing outputs are decoded from the next state so they come straight off flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ld_cnt_q <= '0;
      hp_cnt_q <= '0;
      n_q      <= '0;
      sr1_q    <= '0;
      sr2_q    <= '0;
      addr_q   <= '0;
      shld_q   <= 1'b1;
      serclk_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      hp_cnt_q <= hp_cnt_d;
      n_q      <= n_d;
      sr1_q    <= sr1_d;
      sr2_q    <= sr2_d;
      addr_q   <= addr_d;
      shld_q   <= (state_d != S_LOAD);
      serclk_q <= (state_d == S_HIGH);
      valid_q  <= (state_d == S_DONE);
      busy_q   <= (state_d == S_LOAD) || (state_d == S_LOW) || (state_d == S_HIGH);
    end
  end

  assign o_shld    = shld_q;
  assign o_serclk  = serclk_q;
  assign o_address = addr_q;
  assign o_valid   = valid_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_adr_deserializer.sv
// Directed bench for adr_deserializer: default instance plus a DIV=1/LOAD_CYCLES=1 instance,
// each fed by a behavioural 74HC165 chain pair.
module tb_adr_deserializer;

`ifdef ADR_SYNC_EN
  localparam int N_DEF = 49;
  localparam int N_F   = 33;
  localparam int LOW_F = 3;
`else
  localparam int N_DEF = 33;
  localparam int N_F   = 17;
  localparam int LOW_F = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_d = 1'b0;
  logic start_f = 1'b0;

  logic        adrin1_d, adrin2_d, shld_d, serclk_d, valid_d, busy_d;
  logic [15:0] addr_d;
  logic        adrin1_f, adrin2_f, shld_f, serclk_f, valid_f, busy_f;
  logic [15:0] addr_f;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adr_deserializer dut (
    .clk(clk), .reset(reset), .i_start(start_d),
    .adrin1(adrin1_d), .adrin2(adrin2_d),
    .o_shld(shld_d), .o_serclk(serclk_d), .o_address(addr_d),
    .o_valid(valid_d), .o_busy(busy_d)
  );

  adr_deserializer #(.BITS(8), .DIV(1), .LOAD_CYCLES(1)) dut_f (
    .clk(clk), .reset(reset), .i_start(start_f),
    .adrin1(adrin1_f), .adrin2(adrin2_f),
    .o_shld(shld_f), .o_serclk(serclk_f), .o_address(addr_f),
    .o_valid(valid_f), .o_busy(busy_f)
  );

  // 74HC165 pair: parallel load on SHLD falling, shift on SRCLK rising while SHLD high.
  logic [15:0] par_d = 16'h0;
  logic [15:0] par_f = 16'h0;
  logic [7:0]  c1_d = 8'h0, c2_d = 8'h0, c1_f = 8'h0, c2_f = 8'h0;

  always @(negedge shld_d) begin c1_d = par_d[15:8]; c2_d = par_d[7:0]; end
  always @(posedge serclk_d) if (shld_d) begin c1_d = c1_d << 1; c2_d = c2_d << 1; end
  always @(negedge shld_f) begin c1_f = par_f[15:8]; c2_f = par_f[7:0]; end
  always @(posedge serclk_f) if (shld_f) begin c1_f = c1_f << 1; c2_f = c2_f << 1; end

  assign adrin1_d = c1_d[7];
  assign adrin2_d = c2_d[7];
  assign adrin1_f = c1_f[7];
  assign adrin2_f = c2_f[7];

  // Free-running activity counters; checks use deltas across a capture.
  int edges_d = 0, shlo_d = 0, hi_d = 0, vcnt_d = 0;
  int edges_f = 0, hi_f = 0, lo_f = 0, vcnt_f = 0;

  always @(posedge serclk_d) edges_d++;
  always @(posedge serclk_f) edges_f++;

  always @(negedge clk) begin
    if (!shld_d) shlo_d++;
    if (serclk_d) hi_d++;
    if (valid_d) vcnt_d++;
    if (serclk_f) hi_f++;
    if (shld_f && !serclk_f && busy_f) lo_f++;
    if (valid_f) vcnt_f++;
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One capture on the default instance; inj>0 pulses a second i_start in that cycle.
  task automatic cap(input logic [15:0] val, input logic [15:0] prev, input int inj, input string tag);
    int e0, s0, h0, v0;
    par_d = val;
    e0 = edges_d; s0 = shlo_d; h0 = hi_d; v0 = vcnt_d;
    start_d = 1'b1;
    tick(1);
    start_d = 1'b0;
    chk({tag, "_busy"}, 32'(busy_d), 32'd1);
    chk({tag, "_shld_load"}, 32'(shld_d), 32'd0);
    for (int c = 1; c < N_DEF; c++) begin
      if (c == N_DEF - 1) begin
        chk({tag, "_valid_early"}, 32'(valid_d), 32'd0);
        chk({tag, "_addr_held"}, 32'(addr_d), 32'(prev));
      end
      start_d = (c == inj);
      tick(1);
    end
    start_d = 1'b0;
    chk({tag, "_valid"}, 32'(valid_d), 32'd1);
    chk({tag, "_addr"}, 32'(addr_d), 32'(val));
    chk({tag, "_busy_done"}, 32'(busy_d), 32'd0);
    chk({tag, "_shld_cycles"}, 32'(shlo_d - s0), 32'd2);
    chk({tag, "_srclk_edges"}, 32'(edges_d - e0), 32'd7);
    chk({tag, "_srclk_hi_cycles"}, 32'(hi_d - h0), 32'd14);
    tick(1);
    chk({tag, "_valid_off"}, 32'(valid_d), 32'd0);
    chk({tag, "_addr_keep"}, 32'(addr_d), 32'(val));
    tick(1);
    chk({tag, "_pulses"}, 32'(vcnt_d - v0), 32'd1);
  endtask

  initial begin
    int v0, e0, h0, l0;

    // 1: reset values
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_shld", 32'(shld_d), 32'd1);
    chk("rst_serclk", 32'(serclk_d), 32'd0);
    chk("rst_addr", 32'(addr_d), 32'h0);
    chk("rst_valid", 32'(valid_d), 32'd0);
    chk("rst_busy", 32'(busy_d), 32'd0);

    // 2: basic capture
    cap(16'h7D06, 16'h0000, -1, "t2");

    // 3: back-to-back, first word held until second pulse
    cap(16'hA000, 16'h7D06, -1, "t3a");
    cap(16'h8400, 16'hA000, -1, "t3b");

    // 4: i_start while busy is ignored
    cap(16'h1234, 16'h8400, 10, "t4");
    tick(N_DEF + 4);
    chk("t4_no_requeue", 32'(busy_d), 32'd0);

    // 5: reset mid-capture aborts
    par_d = 16'hFFFF;
    v0 = vcnt_d;
    start_d = 1'b1;
    tick(1);
    start_d = 1'b0;
    tick(14);
    reset = 1'b1;
    tick(1);
    chk("t5_shld", 32'(shld_d), 32'd1);
    chk("t5_serclk", 32'(serclk_d), 32'd0);
    chk("t5_addr", 32'(addr_d), 32'h0);
    chk("t5_valid", 32'(valid_d), 32'd0);
    chk("t5_busy", 32'(busy_d), 32'd0);
    reset = 1'b0;
    tick(N_DEF + 10);
    chk("t5_no_pulse", 32'(vcnt_d - v0), 32'd0);
    cap(16'h0001, 16'h0000, -1, "t5b");

    // 6: DIV=1, LOAD_CYCLES=1 instance
    par_f = 16'hAAAA;
    v0 = vcnt_f; e0 = edges_f; h0 = hi_f; l0 = lo_f;
    start_f = 1'b1;
    tick(1);
    start_f = 1'b0;
    chk("t6_shld_load", 32'(shld_f), 32'd0);
    tick(LOW_F);
    chk("t6_low_phase", 32'(serclk_f), 32'd0);
    tick(1);
    chk("t6_high_phase", 32'(serclk_f), 32'd1);
    tick(1);
    chk("t6_low_again", 32'(serclk_f), 32'd0);
    tick(N_F - 1 - (3 + LOW_F));
    chk("t6_valid_early", 32'(valid_f), 32'd0);
    tick(1);
    chk("t6_valid", 32'(valid_f), 32'd1);
    chk("t6_addr", 32'(addr_f), 32'hAAAA);
    chk("t6_edges", 32'(edges_f - e0), 32'd7);
    chk("t6_hi_cycles", 32'(hi_f - h0), 32'd7);
    chk("t6_lo_cycles", 32'(lo_f - l0), 32'(8 * LOW_F));
    tick(2);
    chk("t6_pulses", 32'(vcnt_f - v0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
